// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-macro signal bundle for the memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              flush;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              v_req;
    logic [ADDR_W-1:0] v_addr;
    logic              v_gnt;
    logic              v_rvalid;
    logic [DATA_W-1:0] v_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              stall_fetch;

    modport master (
        output f_req, f_addr, flush,
        output d_req, d_we, d_addr, d_wdata,
        output v_req, v_addr,
        output mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  v_gnt, v_rvalid, v_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  stall_fetch
    );

    modport slave (
        input  f_req, f_addr, flush,
        input  d_req, d_we, d_addr, d_wdata,
        input  v_req, v_addr,
        input  mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output v_gnt, v_rvalid, v_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output stall_fetch
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-way arbiter for the single-ported unified memory
// Fixed V > D > F priority, with F boosted above D after a run of lost fetch cycles.
module mem_port_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        PORT_F = 2'd0,
        PORT_D = 2'd1,
        PORT_V = 2'd2
    } port_e;

    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_BOOST  = 1'b1
    } state_e;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    state_e                     state_q, state_d;
    logic [3:0]                 starve_q, starve_d;
    logic [MEM_LAT-1:0]         own_vld_q, own_vld_d;
    logic [MEM_LAT-1:0][1:0]    own_port_q, own_port_d;
    logic [DATA_W-1:0]          f_rdata_q, d_rdata_q, v_rdata_q;

    logic                       f_gnt, d_gnt, v_gnt;
    logic                       mem_en, mem_we;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_wdata;
    port_e                      new_port;
    logic                       new_vld;
    logic                       tail_vld;
    logic [1:0]                 tail_port;
    logic                       f_rvalid, d_rvalid, v_rvalid;

    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        v_gnt = 1'b0;
        if (rst) begin
            if (bus.v_req) begin
                v_gnt = 1'b1;
            end else if (state_q == ST_BOOST) begin
                if (bus.f_req)      f_gnt = 1'b1;
                else if (bus.d_req) d_gnt = 1'b1;
            end else begin
                if (bus.d_req)      d_gnt = 1'b1;
                else if (bus.f_req) f_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = f_gnt | d_gnt | v_gnt;
        mem_we    = d_gnt & bus.d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (v_gnt)      mem_addr = bus.v_addr;
        else if (d_gnt) mem_addr = bus.d_addr;
        else if (f_gnt) mem_addr = bus.f_addr;
        if (d_gnt)      mem_wdata = bus.d_wdata;
    end

    always_comb begin
        starve_d = '0;
        if (bus.f_req && !f_gnt) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end
        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (starve_d >= STARVE_LIMIT) state_d = ST_BOOST;
            ST_BOOST:  if (f_gnt || !bus.f_req)      state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    // Flush kills every fetch entry, both those shifting along and the one granted now.
    always_comb begin
        if (v_gnt)      new_port = PORT_V;
        else if (d_gnt) new_port = PORT_D;
        else            new_port = PORT_F;
        new_vld       = mem_en & ~mem_we & ~(f_gnt & bus.flush);
        own_vld_d     = '0;
        own_port_d    = '0;
        own_vld_d[0]  = new_vld;
        own_port_d[0] = new_port;
        for (int i = 1; i < MEM_LAT; i++) begin
            own_vld_d[i]  = own_vld_q[i-1] & ~(bus.flush & (own_port_q[i-1] == PORT_F));
            own_port_d[i] = own_port_q[i-1];
        end
    end

    always_comb begin
        tail_vld  = own_vld_q[MEM_LAT-1];
        tail_port = own_port_q[MEM_LAT-1];
        f_rvalid  = rst & tail_vld & (tail_port == PORT_F) & ~bus.flush;
        d_rvalid  = rst & tail_vld & (tail_port == PORT_D);
        v_rvalid  = rst & tail_vld & (tail_port == PORT_V);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_NORMAL;
            starve_q   <= '0;
            own_vld_q  <= '0;
            own_port_q <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
            v_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            own_vld_q  <= own_vld_d;
            own_port_q <= own_port_d;
            if (f_rvalid) f_rdata_q <= bus.mem_rdata;
            if (d_rvalid) d_rdata_q <= bus.mem_rdata;
            if (v_rvalid) v_rdata_q <= bus.mem_rdata;
        end
    end

    // Returning data is forwarded in the rvalid cycle and held afterwards.
    assign bus.f_gnt       = f_gnt;
    assign bus.d_gnt       = d_gnt;
    assign bus.v_gnt       = v_gnt;
    assign bus.f_rvalid    = f_rvalid;
    assign bus.d_rvalid    = d_rvalid;
    assign bus.v_rvalid    = v_rvalid;
    assign bus.f_rdata     = f_rvalid ? bus.mem_rdata : f_rdata_q;
    assign bus.d_rdata     = d_rvalid ? bus.mem_rdata : d_rdata_q;
    assign bus.v_rdata     = v_rvalid ? bus.mem_rdata : v_rdata_q;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.stall_fetch = bus.f_req & ~f_gnt & rst;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         due;
        int         port;
        logic [7:0] data;
    } ret_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    int         lost  = 0;
    ret_t       retq[$];
    logic [7:0] model_mem [256];
    logic [7:0] env_mem   [256];
    logic [7:0] rd_pipe   [LAT];
    logic [7:0] held      [3];

    logic       o_fg, o_dg, o_vg, o_stall, o_fv, o_dv, o_vv;
    logic [7:0] o_fd, o_dd, o_vd;
    logic       s_dg [6];
    logic       s_fg [6];
    logic       s_st [6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input logic rn, input logic fr, input logic [7:0] fa, input logic fl,
                        input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dwd,
                        input logic vr, input logic [7:0] va);
        logic       eg_f, eg_d, eg_v, boost;
        logic [7:0] ea;
        logic [2:0] ev;
        logic [7:0] ed [3];
        logic       sn_en, sn_we;
        logic [7:0] sn_addr, sn_wdata;
        @(negedge clk);
        rst         = rn;
        bus.f_req   = fr;
        bus.f_addr  = fa;
        bus.flush   = fl;
        bus.d_req   = dr;
        bus.d_we    = dw;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.v_req   = vr;
        bus.v_addr  = va;
        #1;
        boost = (lost >= SMAX);
        eg_v  = rn & vr;
        eg_d  = rn & ~vr & dr & (~boost | ~fr);
        eg_f  = rn & ~vr & fr & (boost | ~dr);
        ea    = eg_v ? va : eg_d ? da : eg_f ? fa : 8'h00;
        check("v_gnt", 32'(bus.v_gnt), 32'(eg_v));
        check("d_gnt", 32'(bus.d_gnt), 32'(eg_d));
        check("f_gnt", 32'(bus.f_gnt), 32'(eg_f));
        check("stall_fetch", 32'(bus.stall_fetch), 32'(rn & fr & ~eg_f));
        check("mem_en", 32'(bus.mem_en), 32'(eg_v | eg_d | eg_f));
        check("mem_we", 32'(bus.mem_we), 32'(eg_d & dw));
        check("mem_addr", 32'(bus.mem_addr), 32'(ea));
        if ((eg_d & dw) || !rn)
            check("mem_wdata", 32'(bus.mem_wdata), 32'((eg_d & dw) ? dwd : 8'h00));
        ev = '0;
        for (int p = 0; p < 3; p++) ed[p] = held[p];
        foreach (retq[i]) begin
            if (retq[i].due == cyc && rn && !(retq[i].port == 0 && fl)) begin
                ev[retq[i].port] = 1'b1;
                ed[retq[i].port] = retq[i].data;
            end
        end
        check("f_rvalid", 32'(bus.f_rvalid), 32'(ev[0]));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(ev[1]));
        check("v_rvalid", 32'(bus.v_rvalid), 32'(ev[2]));
        if (rn) begin
            check("f_rdata", 32'(bus.f_rdata), 32'(ed[0]));
            check("d_rdata", 32'(bus.d_rdata), 32'(ed[1]));
            check("v_rdata", 32'(bus.v_rdata), 32'(ed[2]));
        end
        o_fg = bus.f_gnt;    o_dg = bus.d_gnt;    o_vg = bus.v_gnt;
        o_stall = bus.stall_fetch;
        o_fv = bus.f_rvalid; o_dv = bus.d_rvalid; o_vv = bus.v_rvalid;
        o_fd = bus.f_rdata;  o_dd = bus.d_rdata;  o_vd = bus.v_rdata;
        sn_en = bus.mem_en;  sn_we = bus.mem_we;
        sn_addr = bus.mem_addr; sn_wdata = bus.mem_wdata;

        @(posedge clk);
        #1;
        // memory macro: one access per cycle, read data appears LAT cycles later
        for (int i = LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = (sn_en && !sn_we) ? env_mem[sn_addr] : 8'($urandom);
        if (sn_en && sn_we) env_mem[sn_addr] = sn_wdata;
        bus.mem_rdata = rd_pipe[LAT-1];

        if (!rn) begin
            retq.delete();
            for (int p = 0; p < 3; p++) held[p] = 8'h00;
            lost = 0;
        end else begin
            for (int i = retq.size() - 1; i >= 0; i--) begin
                if (retq[i].due == cyc) begin
                    if (!(retq[i].port == 0 && fl)) held[retq[i].port] = retq[i].data;
                    retq.delete(i);
                end else if (fl && retq[i].port == 0) begin
                    retq.delete(i);
                end
            end
            if (eg_d && dw) model_mem[da] = dwd;
            if (eg_v)                retq.push_back('{cyc + LAT, 2, model_mem[va]});
            else if (eg_d && !dw)    retq.push_back('{cyc + LAT, 1, model_mem[da]});
            else if (eg_f && !fl)    retq.push_back('{cyc + LAT, 0, model_mem[fa]});
            if (fr && !eg_f) lost = (lost < 15) ? lost + 1 : 15;
            else             lost = 0;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            model_mem[i] = v;
            env_mem[i]   = v;
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = 8'h00;
        for (int p = 0; p < 3; p++) held[p] = 8'h00;
        bus.mem_rdata = 8'h00;
        rst = 1'b0;

        // reset with every request high, then release
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h03);
        check("rst_gnt", 32'({o_fg, o_dg, o_vg}), 32'(0));
        step(1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h02, 8'h00, 1'b1, 8'h03);
        check("rst_release_v_gnt", 32'(o_vg), 32'(1));
        idle(4);

        // latency
        model_mem[8'h10] = 8'hA5;
        env_mem[8'h10]   = 8'hA5;
        step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        check("lat_f_gnt", 32'(o_fg), 32'(1));
        idle(1);
        check("lat_early_rvalid", 32'(o_fv), 32'(0));
        idle(1);
        check("lat_f_rvalid", 32'(o_fv), 32'(1));
        check("lat_f_rdata", 32'(o_fd), 32'(8'hA5));
        idle(2);

        // starvation boost
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'h40, 1'b0, 1'b1, 1'b0, 8'(i), 8'h00, 1'b0, 8'h00);
            s_dg[i] = o_dg; s_fg[i] = o_fg; s_st[i] = o_stall;
        end
        for (int i = 0; i < 6; i++) begin
            check("starve_d_gnt", 32'(s_dg[i]), 32'(i != 4));
            check("starve_f_gnt", 32'(s_fg[i]), 32'(i == 4));
            check("starve_stall", 32'(s_st[i]), 32'(i != 4));
        end
        idle(3);

        // flush
        step(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 8'h00);
        check("flush_f_rvalid_t2", 32'(o_fv), 32'(0));
        idle(1);
        check("flush_f_rvalid_t3", 32'(o_fv), 32'(0));
        idle(1);
        check("flush_d_rvalid_t4", 32'(o_dv), 32'(1));
        check("flush_d_rdata_t4", 32'(o_dd), 32'(model_mem[8'h07]));
        idle(2);

        // store then load
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 8'h3C, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00);
        idle(1);
        check("store_no_rvalid", 32'(o_dv), 32'(0));
        idle(1);
        check("load_rvalid", 32'(o_dv), 32'(1));
        check("load_rdata", 32'(o_dd), 32'(8'h3C));
        idle(2);

        // reset while a vector read is in flight
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h30);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        idle(3);
        check("midrst_v_rvalid", 32'(o_vv), 32'(0));
        check("midrst_v_rdata", 32'(o_vd), 32'(0));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0, 8'($urandom_range(0, 15)),
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 8'($urandom_range(0, 15)), 8'($urandom),
                 $urandom_range(0, 5) == 0, 8'($urandom_range(0, 15)));
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
